dot_product_sequencer: RTL and testbench

- Controller that sequences one 16-lane int8 MLP/BRAM dot-product datapath (B vector held in BRAM, A streamed 16 elements/cycle, 4-cycle result latency).
- Loads B into BRAM from a valid/ready stream, accepts dot-product commands, and streams A gap-free with correct first/last framing. Returns each result on a valid/ready port.
- Enforces the datapath rule that BRAM writes never overlap an A stream, since the BRAM din is shared with the A high half.

---
 rtl/dot_product_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_dot_product_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer: sequences a 16-lane int8 BRAM/MLP dot-product datapath (B load, A streaming, result return)
// Ports:
//   i_clk, i_reset_n             clock, asynchronous active-low reset
//   i_bload_* / o_bload_ready    B-vector load stream, written to BRAM starting at address 0
//   i_cmd_* / o_cmd_ready        dot-product command (number of A blocks minus 1)
//   i_a_* / o_a_ready            A block stream, forwarded gap-free during RUN
//   o_dp_*                       registered datapath drive (B write port, A, first/last framing)
//   i_dp_sum, i_dp_valid         datapath result
//   o_res_* / i_res_ready        result return, held until consumed
//   o_b_words                    number of B words currently loaded
//   o_busy, o_err_len, o_err_underrun, i_err_clr   status and sticky errors
//   o_perf_cycles                RUN+DRAIN cycle count of the last result (macro DOT_SEQ_PERF_EN), else 0
module dot_product_sequencer #(
    parameter int N = 8,
    parameter int M = 16,
    parameter int A = 10,
    parameter int S = 48
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [M/2*N-1:0]   i_bload_data,
    input  logic               i_bload_valid,
    input  logic               i_bload_last,
    output logic               o_bload_ready,
    input  logic               i_cmd_valid,
    input  logic [A-2:0]       i_cmd_nblocks,
    output logic               o_cmd_ready,
    input  logic [M*N-1:0]     i_a_data,
    input  logic               i_a_valid,
    output logic               o_a_ready,
    output logic [M/2*N-1:0]   o_dp_b,
    output logic [A-1:0]       o_dp_b_addr,
    output logic               o_dp_wren,
    output logic [M*N-1:0]     o_dp_a,
    output logic               o_dp_first,
    output logic               o_dp_last,
    input  logic [S-1:0]       i_dp_sum,
    input  logic               i_dp_valid,
    output logic [S-1:0]       o_res_sum,
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic [A:0]         o_b_words,
    output logic               o_busy,
    output logic               o_err_len,
    output logic               o_err_underrun,
    input  logic               i_err_clr,
    output logic [15:0]        o_perf_cycles
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, HOLD} state_t;
    state_t       state;
    logic [A-1:0] count;
    logic [A-2:0] remaining;
    logic         started, flushed, skip, discard;
    logic         bload_fire, cmd_fire, len_bad, set_len, set_under;
    logic [A-1:0] waddr;
    logic [A:0]   len_need;
    // Readies are forced low while reset is held so every output reads 0 in reset.
    assign o_bload_ready = i_reset_n && (state == IDLE || state == LOAD);
    assign o_cmd_ready   = i_reset_n && state == IDLE && !i_bload_valid;
    // The first RUN cycle after reset is a flush cycle that does not take A data.
    assign o_a_ready     = i_reset_n && state == RUN && flushed;
    assign o_busy        = state != IDLE || o_res_valid;
    assign bload_fire    = i_bload_valid && o_bload_ready;
    assign cmd_fire      = i_cmd_valid && o_cmd_ready;
    assign waddr         = state == IDLE ? '0 : count;
    assign len_need      = {({1'b0, i_cmd_nblocks} + A'(1)), 1'b0};
    assign len_bad       = len_need > o_b_words;
    assign set_len       = cmd_fire && len_bad;
    assign set_under     = state == RUN && flushed && started && !i_a_valid;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state          <= IDLE;
            count          <= '0;
            remaining      <= '0;
            started        <= 1'b0;
            flushed        <= 1'b0;
            skip           <= 1'b0;
            discard        <= 1'b0;
            o_dp_b         <= '0;
            o_dp_b_addr    <= '0;
            o_dp_wren      <= 1'b0;
            o_dp_a         <= '0;
            o_dp_first     <= 1'b0;
            o_dp_last      <= 1'b0;
            o_res_sum      <= '0;
            o_res_valid    <= 1'b0;
            o_b_words      <= '0;
            o_err_len      <= 1'b0;
            o_err_underrun <= 1'b0;
        end else begin
            o_dp_wren      <= 1'b0;
            o_dp_first     <= 1'b0;
            o_dp_last      <= 1'b0;
            o_dp_a         <= '0;
            o_err_len      <= set_len | (o_err_len & ~i_err_clr);
            o_err_underrun <= set_under | (o_err_underrun & ~i_err_clr);
            // The flush cycle's datapath result is the only one that must be ignored.
            if (i_dp_valid && skip)
                skip <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    if (bload_fire) begin
                        o_dp_wren   <= 1'b1;
                        o_dp_b_addr <= waddr;
                        o_dp_b      <= i_bload_data;
                        count       <= waddr + A'(1);
                        if (state == IDLE)
                            o_b_words <= '0;
                        if (i_bload_last || &waddr) begin
                            o_b_words <= {1'b0, waddr} + (A+1)'(1);
                            state     <= IDLE;
                        end else begin
                            state <= LOAD;
                        end
                    end else if (cmd_fire && !len_bad) begin
                        remaining <= i_cmd_nblocks;
                        started   <= 1'b0;
                        discard   <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (!flushed) begin
                        o_dp_last <= 1'b1;
                        flushed   <= 1'b1;
                        skip      <= 1'b1;
                    end else if (i_a_valid) begin
                        o_dp_a     <= i_a_data;
                        o_dp_first <= !started;
                        o_dp_last  <= remaining == '0;
                        started    <= 1'b1;
                        remaining  <= remaining - (A-1)'(1);
                        if (remaining == '0)
                            state <= DRAIN;
                    end else if (started) begin
                        // A gap mid-stream: close the frame so the datapath address rewinds.
                        o_dp_last <= 1'b1;
                        discard   <= 1'b1;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (i_dp_valid && !skip) begin
                        if (discard) begin
                            state <= IDLE;
                        end else begin
                            o_res_sum   <= i_dp_sum;
                            o_res_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (i_res_ready) begin
                        o_res_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef DOT_SEQ_PERF_EN
    logic [15:0] perf_cnt;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            perf_cnt      <= '0;
            o_perf_cycles <= '0;
        end else begin
            if (cmd_fire)
                perf_cnt <= '0;
            else if ((state == RUN || state == DRAIN) && perf_cnt != 16'hffff)
                perf_cnt <= perf_cnt + 16'd1;
            if (state == DRAIN && i_dp_valid && !skip && !discard)
                o_perf_cycles <= perf_cnt;
        end
    end
`else
    assign o_perf_cycles = '0;
`endif
endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb_dot_product_sequencer: self-checking bench for dot_product_sequencer with a 4-cycle datapath model
module tb_dot_product_sequencer;
    localparam int N = 8;
    localparam int M = 16;
    localparam int A = 10;
    localparam int S = 48;
    logic               i_clk = 1'b0;
    logic               i_reset_n = 1'b1;
    logic [M/2*N-1:0]   i_bload_data = '0;
    logic               i_bload_valid = 1'b0;
    logic               i_bload_last = 1'b0;
    logic               o_bload_ready;
    logic               i_cmd_valid = 1'b0;
    logic [A-2:0]       i_cmd_nblocks = '0;
    logic               o_cmd_ready;
    logic [M*N-1:0]     i_a_data = '0;
    logic               i_a_valid = 1'b0;
    logic               o_a_ready;
    logic [M/2*N-1:0]   o_dp_b;
    logic [A-1:0]       o_dp_b_addr;
    logic               o_dp_wren;
    logic [M*N-1:0]     o_dp_a;
    logic               o_dp_first;
    logic               o_dp_last;
    logic [S-1:0]       i_dp_sum;
    logic               i_dp_valid;
    logic [S-1:0]       o_res_sum;
    logic               o_res_valid;
    logic               i_res_ready = 1'b0;
    logic [A:0]         o_b_words;
    logic               o_busy;
    logic               o_err_len;
    logic               o_err_underrun;
    logic               i_err_clr = 1'b0;
    logic [15:0]        o_perf_cycles;

    dot_product_sequencer #(.N(N), .M(M), .A(A), .S(S)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_bload_data(i_bload_data), .i_bload_valid(i_bload_valid), .i_bload_last(i_bload_last),
        .o_bload_ready(o_bload_ready),
        .i_cmd_valid(i_cmd_valid), .i_cmd_nblocks(i_cmd_nblocks), .o_cmd_ready(o_cmd_ready),
        .i_a_data(i_a_data), .i_a_valid(i_a_valid), .o_a_ready(o_a_ready),
        .o_dp_b(o_dp_b), .o_dp_b_addr(o_dp_b_addr), .o_dp_wren(o_dp_wren), .o_dp_a(o_dp_a),
        .o_dp_first(o_dp_first), .o_dp_last(o_dp_last),
        .i_dp_sum(i_dp_sum), .i_dp_valid(i_dp_valid),
        .o_res_sum(o_res_sum), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_b_words(o_b_words), .o_busy(o_busy), .o_err_len(o_err_len),
        .o_err_underrun(o_err_underrun), .i_err_clr(i_err_clr), .o_perf_cycles(o_perf_cycles)
    );

    always #5 i_clk = ~i_clk;

    // Datapath model: o_valid follows every dp_last by 4 cycles; the sum is set per command.
    logic [3:0]   pipe = '0;
    logic [S-1:0] dp_val = '0;
    always @(posedge i_clk) pipe <= {pipe[2:0], o_dp_last};
    assign i_dp_valid = pipe[3];
    assign i_dp_sum   = dp_val;

    int tests = 0;
    int fails = 0;
    bit need_flush = 1'b1;
    logic [S-1:0] sbq[$];

    typedef struct {
        int           nb;
        int           drop;
        int           pre;
        logic [S-1:0] sum;
        bit           len_err;
    } rec_t;
    rec_t tbl[7];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic rst_chk(input string nm);
        chk({nm, "_ctl"}, {o_bload_ready, o_cmd_ready, o_a_ready, o_dp_wren, o_dp_first, o_dp_last,
                           o_res_valid, o_busy, o_err_len, o_err_underrun}, 0);
        chk({nm, "_words"}, o_b_words, 0);
        chk({nm, "_addr"}, o_dp_b_addr, 0);
        chk({nm, "_a"}, o_dp_a, 0);
        chk({nm, "_b"}, o_dp_b, 0);
        chk({nm, "_sum"}, o_res_sum, 0);
        chk({nm, "_perf"}, o_perf_cycles, 0);
    endtask

    task automatic clear_errs();
        @(negedge i_clk);
        i_err_clr = 1'b1;
        @(negedge i_clk);
        i_err_clr = 1'b0;
        chk("err_clr", {o_err_len, o_err_underrun}, 0);
    endtask

    task automatic load(input int n, input bit gaps);
        logic [M/2*N-1:0] d;
        @(negedge i_clk);
        for (int b = 0; b < n; b++) begin
            d = {$urandom, $urandom};
            i_bload_data  = d;
            i_bload_valid = 1'b1;
            i_bload_last  = (b == n - 1);
            i_cmd_valid   = 1'b1;
            i_cmd_nblocks = '0;
            #1 chk("load_ready", {o_bload_ready, o_cmd_ready}, 2'b10);
            @(negedge i_clk);
            chk("load_wr", {o_dp_wren, o_dp_b_addr}, {1'b1, A'(b)});
            chk("load_b", o_dp_b, d);
            if (b == 0 && n > 1) chk("load_clr", o_b_words, 0);
            if (gaps && b < n - 1) begin
                i_bload_valid = 1'b0;
                @(negedge i_clk);
                chk("load_gap", {o_dp_wren, o_cmd_ready}, 0);
            end
        end
        i_bload_valid = 1'b0;
        i_bload_last  = 1'b0;
        i_cmd_valid   = 1'b0;
        chk("b_words", o_b_words, n);
    endtask

    task automatic run_cmd(input int nb, input int drop, input int pre, input logic [S-1:0] sum,
                           input bit len_err, input bit clr_same);
        logic [M*N-1:0] d;
        int lat;
        bit seen;
        bit under;
        under = drop >= 0 && drop <= nb;
        @(negedge i_clk);
        i_cmd_valid   = 1'b1;
        i_cmd_nblocks = (A-1)'(nb);
        i_err_clr     = clr_same;
        dp_val        = sum;
        if (!len_err && !under) sbq.push_back(sum);
        #1 chk("cmd_ready", o_cmd_ready, 1);
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        i_err_clr   = 1'b0;
        if (len_err) begin
            chk("err_len", o_err_len, 1);
            chk("len_busy", o_busy, 0);
            seen = 1'b0;
            repeat (6) begin
                @(negedge i_clk);
                seen |= o_dp_first | o_dp_last | o_a_ready;
            end
            chk("len_no_run", seen, 0);
            return;
        end
        if (need_flush) begin
            chk("flush_ready", o_a_ready, 0);
            @(negedge i_clk);
            chk("flush_frame", {o_dp_first, o_dp_last}, 2'b01);
            chk("flush_a", o_dp_a, 0);
            need_flush = 1'b0;
        end
        repeat (pre) begin
            @(negedge i_clk);
            chk("pre_wait", {o_dp_first, o_dp_last, o_err_underrun}, 0);
        end
        for (int i = 0; i <= nb; i++) begin
            if (i == drop) begin
                i_a_valid = 1'b0;
                @(negedge i_clk);
                chk("under_frame", {o_dp_first, o_dp_last}, 2'b01);
                chk("under_a", o_dp_a, 0);
                chk("err_under", o_err_underrun, 1);
                break;
            end
            chk("a_ready", o_a_ready, 1);
            d = {$urandom, $urandom, $urandom, $urandom};
            i_a_data  = d;
            i_a_valid = 1'b1;
            @(negedge i_clk);
            chk("dp_frame", {o_dp_first, o_dp_last, o_dp_wren}, {i == 0, i == nb, 1'b0});
            chk("dp_a", o_dp_a, d);
        end
        i_a_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge i_clk);
            if (o_res_valid) begin
                lat = c;
                break;
            end
        end
        if (under) begin
            chk("under_no_res", lat, 0);
            chk("under_idle", o_busy, 0);
            clear_errs();
            return;
        end
        chk("res_latency", lat, 5);
        repeat (3) begin
            @(negedge i_clk);
            chk("res_hold", {o_res_valid, o_res_sum}, {1'b1, sbq[0]});
        end
        chk("res_sum", o_res_sum, sbq.pop_front());
        i_res_ready = 1'b1;
        @(negedge i_clk);
        i_res_ready = 1'b0;
        chk("res_release", {o_res_valid, o_busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{nb: 3,  drop: -1, pre: 0, sum: 48'd1234,           len_err: 1'b0};
        tbl[1] = '{nb: 32, drop: -1, pre: 0, sum: 48'd0,              len_err: 1'b1};
        tbl[2] = '{nb: 0,  drop: -1, pre: 0, sum: 48'hFFFF_FFFF_FFB3, len_err: 1'b0};
        tbl[3] = '{nb: 7,  drop: 3,  pre: 0, sum: 48'd0,              len_err: 1'b0};
        tbl[4] = '{nb: 31, drop: -1, pre: 2, sum: 48'h0100_0000_0005, len_err: 1'b0};
        tbl[5] = '{nb: 1,  drop: 1,  pre: 1, sum: 48'd0,              len_err: 1'b0};
        tbl[6] = '{nb: 2,  drop: -1, pre: 0, sum: 48'd555,            len_err: 1'b0};
        #2 i_reset_n = 1'b0;
        repeat (2) @(negedge i_clk);
        rst_chk("reset");
        i_reset_n = 1'b1;
        @(negedge i_clk);
        chk("idle_ready", {o_bload_ready, o_cmd_ready, o_busy}, 3'b110);
        load(1, 1'b0);
        run_cmd(0, -1, 0, 48'd0, 1'b1, 1'b1);
        clear_errs();
        load(64, 1'b1);
        load(64, 1'b0);
        for (int t = 0; t < 7; t++) begin
            run_cmd(tbl[t].nb, tbl[t].drop, tbl[t].pre, tbl[t].sum, tbl[t].len_err, 1'b0);
            if (tbl[t].len_err) clear_errs();
        end
        @(negedge i_clk);
        i_cmd_valid   = 1'b1;
        i_cmd_nblocks = 9'd7;
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        i_a_data    = {$urandom, $urandom, $urandom, $urandom};
        i_a_valid   = 1'b1;
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b0;
        i_a_valid = 1'b0;
        #1 rst_chk("midrun_reset");
        @(negedge i_clk);
        i_reset_n  = 1'b1;
        need_flush = 1'b1;
        load(16, 1'b0);
        run_cmd(3, -1, 0, 48'd4321, 1'b0, 1'b0);
        run_cmd(8, -1, 0, 48'd0, 1'b1, 1'b0);
        clear_errs();
        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
